// File: rtl/pulse_seq_ctrl.sv
// Board-level controller for the pulse-mode "x1 - x2 - x2" sequence detector:
// input conditioning, detector state register, stretched z and detection counter.
module pulse_seq_ctrl #(
  parameter int DEB_CYCLES = 1000000,
  parameter int Z_HOLD     = 50000000,
  parameter int CNT_W      = 4
) (
  input  logic             clk,
  input  logic             rd,
  input  logic             btn_x1,
  input  logic             btn_x2,
  output logic [1:0]       y,
  output logic             found,
  output logic             z,
  output logic [CNT_W-1:0] match_cnt,
  output logic             collide
);

  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;
  localparam int HW = (Z_HOLD > 1) ? $clog2(Z_HOLD + 1) : 1;
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(Z_HOLD - 1);

  typedef enum logic [1:0] {
    S00 = 2'b00,
    S01 = 2'b01,
    S10 = 2'b10,
    S11 = 2'b11
  } state_t;

  // Bit 0 carries x1, bit 1 carries x2 through the conditioning pipeline.
  logic [1:0]         raw;
  logic [1:0]         sync1;
  logic [1:0]         sync2;
  logic [1:0]         prime;
  logic [1:0]         stable;
  logic [1:0]         armed;
  logic [1:0]         pulse;
  logic [1:0][DW-1:0] deb_cnt;

  state_t             state;
  logic [HW-1:0]      hold;
  logic               valid_x1;
  logic               valid_x2;

  assign raw = {btn_x2, btn_x1};

  // prime[1] marks that sync2 holds a real sample rather than its reset value;
  // an input is only armed once it has been seen low, so a level held through
  // reset release never turns into a press.
  always_ff @(posedge clk or negedge rd) begin
    if (!rd) begin
      sync1   <= '0;
      sync2   <= '0;
      prime   <= '0;
      stable  <= '0;
      armed   <= '0;
      pulse   <= '0;
      deb_cnt <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      prime <= {prime[0], 1'b1};
      for (int i = 0; i < 2; i++) begin
        pulse[i] <= 1'b0;
        if (prime[1] && !sync2[i]) begin
          armed[i] <= 1'b1;
        end
        if (sync2[i] == stable[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          deb_cnt[i] <= '0;
          stable[i]  <= sync2[i];
          pulse[i]   <= sync2[i] & armed[i];
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign valid_x1 = pulse[0] & ~pulse[1];
  assign valid_x2 = pulse[1] & ~pulse[0];
  assign collide  = pulse[0] & pulse[1];

  // Detector state, detection counter and z stretcher. A detection reloads the
  // hold counter even while z is already high, so back-to-back events merge.
  always_ff @(posedge clk or negedge rd) begin
    if (!rd) begin
      state     <= S00;
      hold      <= '0;
      z         <= 1'b0;
      match_cnt <= '0;
    end else begin
      if (z) begin
        if (hold == '0) begin
          z <= 1'b0;
        end else begin
          hold <= hold - 1'b1;
        end
      end
      if (valid_x1 || valid_x2) begin
        if (state == S11) begin
          match_cnt <= match_cnt + 1'b1;
          hold      <= HOLD_LOAD;
          z         <= 1'b1;
        end
        if (valid_x1) begin
          state <= S10;
        end else begin
          unique case (state)
            S00: state <= S00;
            S01: state <= S11;
            S10: state <= S01;
            S11: state <= S00;
          endcase
        end
      end
    end
  end

  assign y     = state;
  assign found = (state == S11);

endmodule

// File: tb/tb_pulse_seq_ctrl.sv
// Directed bench for pulse_seq_ctrl: one instance with DEB_CYCLES=4 for the
// sequence/bounce/collision steps, one with DEB_CYCLES=1 for retrigger and reset.
module tb_pulse_seq_ctrl;

  logic       clk;
  logic       rd;
  logic       bx1, bx2;
  logic       fx1, fx2;
  logic [1:0] y, y1;
  logic       found, found1;
  logic       z, z1;
  logic [3:0] cnt, cnt1;
  logic       collide, collide1;

  int total  = 0;
  int passed = 0;

  pulse_seq_ctrl #(.DEB_CYCLES(4), .Z_HOLD(8), .CNT_W(4)) dut (
    .clk(clk), .rd(rd), .btn_x1(bx1), .btn_x2(bx2),
    .y(y), .found(found), .z(z), .match_cnt(cnt), .collide(collide)
  );

  pulse_seq_ctrl #(.DEB_CYCLES(1), .Z_HOLD(8), .CNT_W(4)) dut1 (
    .clk(clk), .rd(rd), .btn_x1(fx1), .btn_x2(fx2),
    .y(y1), .found(found1), .z(z1), .match_cnt(cnt1), .collide(collide1)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clean press on the DEB_CYCLES=4 instance: rise at k=0, release at k=10.
  task automatic press(input bit sel, input logic [1:0] yb, input logic [1:0] ya,
                       input bit det, input logic [3:0] cb, input logic [3:0] ca);
    @(posedge clk); #1;
    if (sel) bx2 = 1'b1; else bx1 = 1'b1;
    for (int k = 1; k < 20; k++) begin
      @(posedge clk); #1;
      if (k == 10) begin bx1 = 1'b0; bx2 = 1'b0; end
      if (k == 6) begin
        check("y_before_edge", 32'(y), 32'(yb));
        check("z_before_det", 32'(z), 0);
        check("cnt_before", 32'(cnt), 32'(cb));
        check("collide_single", 32'(collide), 0);
      end
      if (k == 7) check("y_after_7", 32'(y), 32'(ya));
      if (det && k >= 7 && k <= 14) check("z_stretch", 32'(z), 1);
      if (k == 15) check("z_drop", 32'(z), 0);
      if (k == 19) begin
        check("y_after_release", 32'(y), 32'(ya));
        check("found", 32'(found), (ya == 2'b11) ? 1 : 0);
        check("cnt_after", 32'(cnt), 32'(ca));
      end
    end
  endtask

  // Short press on the DEB_CYCLES=1 instance; pulse lands at k=3, y at k=4.
  task automatic press_fast(input bit sel);
    @(posedge clk); #1;
    if (sel) fx2 = 1'b1; else fx1 = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      if (k == 2) begin fx1 = 1'b0; fx2 = 1'b0; end
    end
  endtask

  // From y=11: x1 pulse at k=3 (detection), x2 at k=4 and k=6, x1 at k=8 (detection).
  task automatic burst(input logic [3:0] base, input int stop_at);
    @(posedge clk); #1;
    fx1 = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      @(posedge clk); #1;
      case (k)
        1: begin fx1 = 1'b0; fx2 = 1'b1; end
        2: fx2 = 1'b0;
        3: fx2 = 1'b1;
        5: begin fx1 = 1'b1; fx2 = 1'b0; end
        7: fx1 = 1'b0;
        default: ;
      endcase
      if (k == 3) begin
        check("burst_z_idle", 32'(z1), 0);
        check("burst_y_start", 32'(y1), 32'h3);
      end
      if (k >= 4 && k <= 16) check("burst_z_continuous", 32'(z1), 1);
      if (k == 4) begin
        check("burst_y_det1", 32'(y1), 32'h2);
        check("burst_cnt_det1", 32'(cnt1), 32'(base + 4'd1));
      end
      if (k == 5) check("burst_y_x2a", 32'(y1), 32'h1);
      if (k == 7) begin
        check("burst_y_x2b", 32'(y1), 32'h3);
        check("burst_cnt_mid", 32'(cnt1), 32'(base + 4'd1));
      end
      if (k == 9) begin
        check("burst_y_det2", 32'(y1), 32'h2);
        check("burst_cnt_det2", 32'(cnt1), 32'(base + 4'd2));
      end
      if (k == 17) check("burst_z_end", 32'(z1), 0);
      if (k == stop_at) return;
    end
  endtask

  initial begin
    rd  = 1'b1;
    bx1 = 1'b0; bx2 = 1'b0; fx1 = 1'b0; fx2 = 1'b0;
    #2 rd = 1'b0;
    #1;
    check("rst_y", 32'(y), 0);
    check("rst_found", 32'(found), 0);
    check("rst_z", 32'(z), 0);
    check("rst_cnt", 32'(cnt), 0);
    check("rst_collide", 32'(collide), 0);
    repeat (3) @(posedge clk);
    #1 rd = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("post_rst_y", 32'(y), 0);

    // clean x1, x2, x2
    press(1'b0, 2'b00, 2'b10, 1'b0, 4'd0, 4'd0);
    press(1'b1, 2'b10, 2'b01, 1'b0, 4'd0, 4'd0);
    press(1'b1, 2'b01, 2'b11, 1'b0, 4'd0, 4'd0);

    // detections by x1 and by x2
    press(1'b0, 2'b11, 2'b10, 1'b1, 4'd0, 4'd1);
    press(1'b1, 2'b10, 2'b01, 1'b0, 4'd1, 4'd1);
    press(1'b1, 2'b01, 2'b11, 1'b0, 4'd1, 4'd1);
    press(1'b1, 2'b11, 2'b00, 1'b1, 4'd1, 4'd2);

    // bounce on press (final rise at k=20) and on release (final fall at k=60)
    @(posedge clk); #1;
    bx1 = 1'b1;
    for (int k = 1; k < 80; k++) begin
      @(posedge clk); #1;
      if (k < 20)      bx1 = ((k / 2) % 2 == 0);
      else if (k < 40) bx1 = 1'b1;
      else if (k < 60) bx1 = ((k / 2) % 2 == 1);
      else             bx1 = 1'b0;
      if (k == 10) check("bounce_y_early", 32'(y), 0);
      if (k == 26) check("bounce_y_before", 32'(y), 0);
      if (k == 27) check("bounce_y_after", 32'(y), 32'h2);
      if (k == 79) check("bounce_release_y", 32'(y), 32'h2);
    end

    // collision from y=01
    press(1'b1, 2'b10, 2'b01, 1'b0, 4'd2, 4'd2);
    @(posedge clk); #1;
    bx1 = 1'b1; bx2 = 1'b1;
    for (int k = 1; k < 20; k++) begin
      @(posedge clk); #1;
      if (k == 10) begin bx1 = 1'b0; bx2 = 1'b0; end
      if (k == 5) check("collide_pre", 32'(collide), 0);
      if (k == 6) check("collide_hit", 32'(collide), 1);
      if (k == 7) begin
        check("collide_clear", 32'(collide), 0);
        check("collide_y", 32'(y), 32'h1);
      end
      if (k == 19) begin
        check("collide_y_end", 32'(y), 32'h1);
        check("collide_cnt", 32'(cnt), 32'h2);
      end
    end

    // retrigger on the fast instance
    press_fast(1'b0);
    check("fast_y_10", 32'(y1), 32'h2);
    press_fast(1'b1);
    check("fast_y_01", 32'(y1), 32'h1);
    press_fast(1'b1);
    check("fast_y_11", 32'(y1), 32'h3);
    burst(4'd0, -1);
    press_fast(1'b1);
    press_fast(1'b1);
    check("fast_y_11b", 32'(y1), 32'h3);
    burst(4'd2, -1);
    press_fast(1'b1);
    press_fast(1'b1);
    burst(4'd4, 7);
    check("pre_rst_z", 32'(z1), 1);
    check("pre_rst_cnt", 32'(cnt1), 32'h5);

    // asynchronous reset mid-hold, x2 held through release
    fx2 = 1'b1;
    #2 rd = 1'b0;
    #1;
    check("async_y", 32'(y1), 0);
    check("async_found", 32'(found1), 0);
    check("async_z", 32'(z1), 0);
    check("async_cnt", 32'(cnt1), 0);
    check("async_collide", 32'(collide1), 0);
    repeat (3) @(posedge clk);
    #1 rd = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("held_x2_y", 32'(y1), 0);
    check("held_x2_cnt", 32'(cnt1), 0);

    // x1 held through a second reset must not reach y=10 until re-pressed
    fx2 = 1'b0; fx1 = 1'b1;
    #1 rd = 1'b0;
    @(posedge clk);
    #1 rd = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("held_x1_y", 32'(y1), 0);
    fx1 = 1'b0;
    repeat (6) @(posedge clk);
    press_fast(1'b0);
    check("rearm_x1_y", 32'(y1), 32'h2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
